// File: rtl/spill_arb_pkg.sv
// Shared types and helpers for the spill round-robin arbiter.
// The optional flush logic is enabled by defining SPILL_RR_ARBITER_FLUSH_EN.
package spill_arb_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CntEmpty = 2'd0;
  localparam cnt_t CntFull  = 2'd2;

  // Wrapping increment used to advance the round-robin pointer past a grant.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spill_arb_stage.sv
// Two-entry {data, idx} spill buffer: head feeds the output flops directly,
// spill holds a second beat so upstream ready never waits on downstream ready.
module spill_arb_stage
  import spill_arb_pkg::*;
#(
  parameter type T    = logic,
  parameter int  IdxW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush,
  input  logic            push,
  input  T                push_data,
  input  logic [IdxW-1:0] push_idx,
  input  logic            pop,
  output cnt_t            cnt,
  output T                head_data,
  output logic [IdxW-1:0] head_idx
);

  T                spill_data;
  logic [IdxW-1:0] spill_idx;

  // Push lands behind any existing head; a pop promotes spill to head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= CntEmpty;
      head_data  <= '0;
      head_idx   <= '0;
      spill_data <= '0;
      spill_idx  <= '0;
    end else if (flush) begin
      cnt <= CntEmpty;
    end else if (push && !pop) begin
      if (cnt == CntEmpty) begin
        head_data <= push_data;
        head_idx  <= push_idx;
      end else begin
        spill_data <= push_data;
        spill_idx  <= push_idx;
      end
      cnt <= cnt + 2'd1;
    end else if (!push && pop) begin
      head_data <= spill_data;
      head_idx  <= spill_idx;
      cnt       <= cnt - 2'd1;
    end else if (push && pop) begin
      // Simultaneous push/pop keeps the count; with one beat the new one becomes head.
      if (cnt == 2'd1) begin
        head_data <= push_data;
        head_idx  <= push_idx;
      end else begin
        head_data  <= spill_data;
        head_idx   <= spill_idx;
        spill_data <= push_data;
        spill_idx  <= push_idx;
      end
    end
  end

endmodule

// File: rtl/spill_rr_arbiter.sv
// Round-robin arbiter feeding one registered two-entry spill stage.
// Define SPILL_RR_ARBITER_FLUSH_EN to make flush_i clear the buffered beats.
module spill_rr_arbiter
  import spill_arb_pkg::*;
#(
  parameter type T     = logic,
  parameter int  NumIn = 4,
  parameter int  IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [NumIn-1:0]    inp_valid_i,
  output logic [NumIn-1:0]    inp_ready_o,
  input  T     [NumIn-1:0]    inp_data_i,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output T                    oup_data_o,
  output logic [IdxW-1:0]     oup_idx_o
);

  logic            flush;
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] grant;
  logic            grant_valid;
  logic            push;
  logic            pop;
  cnt_t            cnt;

`ifdef SPILL_RR_ARBITER_FLUSH_EN
  assign flush = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush        = 1'b0;
`endif

  // Scan requesters starting at the pointer, wrapping past the last input.
  always_comb begin
    int c;
    logic [IdxW-1:0] cand;
    grant_valid = 1'b0;
    grant       = '0;
    c           = 0;
    cand        = '0;
    for (int k = 0; k < NumIn; k++) begin
      c = int'(rr_q) + k;
      if (c >= NumIn) c = c - NumIn;
      cand = IdxW'(c);
      if (!grant_valid && inp_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  // Ready depends only on local state and valids, never on oup_ready_i.
  assign push = grant_valid && (cnt < CntFull) && !flush && !rst_i;
  assign pop  = oup_valid_o && oup_ready_i;

  always_comb begin
    inp_ready_o = '0;
    if (push) inp_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= IdxW'(rr_next(int'(grant), NumIn));
    end
  end

  assign oup_valid_o = (cnt != CntEmpty);

  spill_arb_stage #(
    .T    (T),
    .IdxW (IdxW)
  ) u_stage (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (flush),
    .push      (push),
    .push_data (inp_data_i[grant]),
    .push_idx  (grant),
    .pop       (pop),
    .cnt       (cnt),
    .head_data (oup_data_o),
    .head_idx  (oup_idx_o)
  );

endmodule
